// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   // Physical pin level for a logical anode enable under the chosen polarity.
   function automatic logic anode_level(input logic asserted, input logic active_low);
      return asserted ^ active_low;
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module seg_scan_timer #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         done_q, done_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = W'(cnt_q - W'(1));
      end
      done_d = (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         done_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit display scanner with per-digit blanking gap and per-frame snapshot.
// Optional macro SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression of the upper digits.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS       = 2,
   parameter int unsigned DIGIT_W          = 4,
   parameter int unsigned SHOW_CYCLES      = 20000,
   parameter int unsigned BLANK_CYCLES     = 200,
   parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          en,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
   output logic [DIGIT_W-1:0]            digit_out,
   output logic [NUM_DIGITS-1:0]         anode,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_start
);

   localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
   localparam int unsigned DATA_W     = NUM_DIGITS * DIGIT_W;
   localparam int unsigned MAX_CYC    = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int unsigned TMR_W      = $clog2(MAX_CYC + 1);
   localparam int unsigned SHOW_LOAD  = SHOW_CYCLES - 1;
   localparam int unsigned BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
   localparam int unsigned LAST_IDX   = NUM_DIGITS - 1;
   localparam logic        ANODE_OFF  = anode_level(1'b0, ANODE_ACTIVE_LOW);
   localparam logic        ANODE_ON   = anode_level(1'b1, ANODE_ACTIVE_LOW);

   scan_state_t           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_W-1:0]     snap_q, snap_d;
   logic [DIGIT_W-1:0]    digit_out_q, digit_out_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic                  frame_start_q, frame_start_d;
   logic                  new_frame;
   logic                  tmr_load, tmr_done, lz_hide;
   logic [TMR_W-1:0]      tmr_load_val;

   seg_scan_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .done     (tmr_done)
   );

   // State register together with the slot index and frame snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
      end
   end

   // Next state; a zero-length gap sends each slot straight into SHOW.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      snap_d       = snap_q;
      new_frame    = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      case (state_q)
         IDLE: begin
            if (en) begin
               new_frame = 1'b1;
               idx_d     = '0;
               snap_d    = digits;
               tmr_load  = 1'b1;
               if (BLANK_CYCLES > 0) begin
                  state_d      = BLANK;
                  tmr_load_val = TMR_W'(BLANK_LOAD);
               end else begin
                  state_d      = SHOW;
                  tmr_load_val = TMR_W'(SHOW_LOAD);
               end
            end
         end
         BLANK: begin
            if (tmr_done) begin
               state_d      = SHOW;
               tmr_load     = 1'b1;
               tmr_load_val = TMR_W'(SHOW_LOAD);
            end
         end
         SHOW: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               if (idx_q == IDX_W'(LAST_IDX)) begin
                  idx_d     = '0;
                  snap_d    = digits;
                  new_frame = 1'b1;
               end else begin
                  idx_d = IDX_W'(idx_q + IDX_W'(1));
               end
               if (BLANK_CYCLES > 0) begin
                  state_d      = BLANK;
                  tmr_load_val = TMR_W'(BLANK_LOAD);
               end else begin
                  state_d      = SHOW;
                  tmr_load_val = TMR_W'(SHOW_LOAD);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!en) begin
         state_d   = IDLE;
         idx_d     = '0;
         snap_d    = snap_q;
         new_frame = 1'b0;
         tmr_load  = 1'b0;
      end
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   // Hide a slot when it and every more-significant digit are zero; slot 0 always shows.
   always_comb begin
      lz_hide = (idx_d != '0);
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if ((k >= 32'(idx_d)) && (snap_d[k*DIGIT_W +: DIGIT_W] != '0)) begin
            lz_hide = 1'b0;
         end
      end
   end
`else
   assign lz_hide = 1'b0;
`endif

   // Output decode from the upcoming state so every output leaves a flop.
   always_comb begin
      anode_d       = {NUM_DIGITS{ANODE_OFF}};
      digit_out_d   = digit_out_q;
      frame_start_d = new_frame;
      if (state_d != IDLE) begin
         digit_out_d = snap_d[idx_d*DIGIT_W +: DIGIT_W];
      end
      if ((state_d == SHOW) && !lz_hide) begin
         anode_d[idx_d] = ANODE_ON;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         anode_q       <= {NUM_DIGITS{ANODE_OFF}};
         digit_out_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         anode_q       <= anode_d;
         digit_out_q   <= digit_out_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign anode       = anode_q;
   assign digit_out   = digit_out_q;
   assign digit_idx   = idx_q;
   assign frame_start = frame_start_q;

endmodule
